// File: rtl/hsv_core_dispatch.sv
// hsv_core_dispatch: N-unit dispatch stage. Routes each issued instruction to a
// per-unit FWFT FIFO and tags it with a wrapping program-order token. In-flight
// instructions are limited by a credit counter that commit retirement decrements.
// The stage takes part in the core flush_req/flush_ack handshake.
// Optional macro HSV_DISPATCH_STATS_EN: adds 32-bit saturating per-unit stall
// counters on stall_count_o. When the macro is undefined, stall_count_o is tied to 0.
module hsv_core_dispatch #(
  parameter int unsigned N_UNITS      = 5,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned TOKEN_W      = 4,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                         clk_core,
  input  logic                         rst_core,
  input  logic                         flush_req,
  output logic                         flush_ack,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DATA_W-1:0]            data_i,
  input  logic [$clog2(N_UNITS)-1:0]   unit_sel_i,
  output logic [N_UNITS-1:0]           unit_valid_o,
  input  logic [N_UNITS-1:0]           unit_ready_i,
  output logic [N_UNITS*DATA_W-1:0]    unit_data_o,
  output logic [N_UNITS*TOKEN_W-1:0]   unit_token_o,
  input  logic                         retire_i,
  output logic                         err_o,
  output logic [N_UNITS*32-1:0]        stall_count_o
);

  localparam int unsigned SEL_W = $clog2(N_UNITS);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned INF_W = TOKEN_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [TOKEN_W-1:0] token;
  } entry_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_flush_ack;
  logic               w_flush_ack_nxt;

  logic [TOKEN_W-1:0] r_token;
  logic [INF_W-1:0]   r_inflight;
  logic               r_err;

  entry_t             r_mem  [N_UNITS][DEPTH];
  logic [PTR_W-1:0]   r_wptr [N_UNITS];
  logic [PTR_W-1:0]   r_rptr [N_UNITS];

  logic [N_UNITS-1:0] w_full;
  logic [N_UNITS-1:0] w_empty;
  logic [N_UNITS-1:0] w_push;
  logic [N_UNITS-1:0] w_pop;
  logic [N_UNITS-1:0] w_unit_valid;
  entry_t             w_head [N_UNITS];

  logic               w_run;
  logic               w_clear;
  logic               w_sel_legal;
  logic               w_sel_full;
  logic               w_ready;
  logic               w_accept;
  logic               w_push_any;
  logic               w_inc;
  logic               w_dec;

  assign w_run       = (r_state == ST_RUN);
  // Entering FLUSH clears every FIFO and zeroes the in-flight count at that same edge.
  assign w_clear     = w_run & flush_req;
  assign w_sel_legal = (32'(unit_sel_i) < N_UNITS);

  // Fullness of the selected unit. An illegal selection reads as not full.
  always_comb begin
    w_sel_full = 1'b0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (unit_sel_i == SEL_W'(i)) w_sel_full = w_full[i];
    end
  end

  assign w_ready    = w_run & ~flush_req & (r_inflight < INF_W'(MAX_INFLIGHT))
                    & (~w_sel_legal | ~w_sel_full);
  assign w_accept   = valid_i & w_ready;
  assign w_push_any = w_accept & w_sel_legal;
  assign w_inc      = w_push_any;
  assign w_dec      = retire_i & w_run & (r_inflight != '0);

  // Per-unit FIFO status, head extraction and output mapping.
  for (genvar g = 0; g < N_UNITS; g++) begin : g_unit
    assign w_full[g]       = (r_wptr[g][IDX_W-1:0] == r_rptr[g][IDX_W-1:0])
                           & (r_wptr[g][IDX_W] != r_rptr[g][IDX_W]);
    assign w_empty[g]      = (r_wptr[g] == r_rptr[g]);
    assign w_head[g]       = r_mem[g][r_rptr[g][IDX_W-1:0]];
    assign w_unit_valid[g] = ~w_empty[g] & w_run;
    assign w_pop[g]        = w_unit_valid[g] & unit_ready_i[g];
    assign w_push[g]       = w_push_any & (unit_sel_i == SEL_W'(g));
    assign unit_data_o[g*DATA_W +: DATA_W]    = w_head[g].data;
    assign unit_token_o[g*TOKEN_W +: TOKEN_W] = w_head[g].token;
  end

  // FSM state and registered flush acknowledge.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_state     <= ST_RUN;
      r_flush_ack <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_ack <= w_flush_ack_nxt;
    end
  end

  // FSM next state. The acknowledge tracks the state that will be held after the edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_ack_nxt = 1'b0;
    case (r_state)
      ST_RUN:   if (flush_req)  w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (!flush_req) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
    w_flush_ack_nxt = (w_state_nxt == ST_FLUSH);
  end

  // FIFO pointers. Push and pop are independent; a push is only ever granted when not full.
  always_ff @(posedge clk_core) begin
    for (int i = 0; i < N_UNITS; i++) begin
      if (rst_core || w_clear) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end else begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
      end
    end
  end

  // FIFO storage. Contents need no reset because the pointers define validity.
  always_ff @(posedge clk_core) begin
    for (int i = 0; i < N_UNITS; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i][IDX_W-1:0]] <= '{data: data_i, token: r_token};
    end
  end

  // Program-order token. Flush leaves it running so ordering continues after the flush.
  always_ff @(posedge clk_core) begin
    if (rst_core)        r_token <= '0;
    else if (w_push_any) r_token <= r_token + TOKEN_W'(1);
  end

  // In-flight credit counter. A retire seen at zero is dropped.
  always_ff @(posedge clk_core) begin
    if (rst_core || w_clear) begin
      r_inflight <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_inflight <= r_inflight + INF_W'(1);
        2'b01:   r_inflight <= r_inflight - INF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // One-cycle error pulse for an accepted out-of-range unit select.
  always_ff @(posedge clk_core) begin
    if (rst_core) r_err <= 1'b0;
    else          r_err <= w_accept & ~w_sel_legal;
  end

`ifdef HSV_DISPATCH_STATS_EN
  logic [31:0]        r_stall [N_UNITS];
  logic [N_UNITS-1:0] w_stall_inc;

  // A unit stalls while issue targets it during RUN, its FIFO is full and no flush is requested.
  for (genvar g = 0; g < N_UNITS; g++) begin : g_stall
    assign w_stall_inc[g] = w_run & ~flush_req & valid_i & (unit_sel_i == SEL_W'(g)) & w_full[g];
    assign stall_count_o[g*32 +: 32] = r_stall[g];
  end

  // Saturating stall counters. Only reset clears them; a flush does not.
  always_ff @(posedge clk_core) begin
    for (int i = 0; i < N_UNITS; i++) begin
      if (rst_core)                                r_stall[i] <= '0;
      else if (w_stall_inc[i] && (r_stall[i] != '1)) r_stall[i] <= r_stall[i] + 32'd1;
    end
  end
`else
  assign stall_count_o = '0;
`endif

  assign flush_ack    = r_flush_ack;
  assign ready_o      = w_ready;
  assign unit_valid_o = w_unit_valid;
  assign err_o        = r_err;

endmodule

// File: tb/tb_hsv_core_dispatch.sv
// Bench for hsv_core_dispatch. A queue-based reference model predicts every output
// each cycle. Directed scenarios pin hand-computed values, and a randomized phase follows.
module tb_hsv_core_dispatch;

  localparam int N   = 5;
  localparam int DW  = 128;
  localparam int DEP = 2;
  localparam int TW  = 4;
  localparam int MI  = 8;

  logic              clk_core = 1'b0;
  logic              rst_core;
  logic              flush_req;
  logic              flush_ack;
  logic              valid_i;
  logic              ready_o;
  logic [DW-1:0]     data_i;
  logic [2:0]        unit_sel_i;
  logic [N-1:0]      unit_valid_o;
  logic [N-1:0]      unit_ready_i;
  logic [N*DW-1:0]   unit_data_o;
  logic [N*TW-1:0]   unit_token_o;
  logic              retire_i;
  logic              err_o;
  logic [N*32-1:0]   stall_count_o;

  hsv_core_dispatch #(
    .N_UNITS(N), .DATA_W(DW), .DEPTH(DEP), .TOKEN_W(TW), .MAX_INFLIGHT(MI)
  ) dut (
    .clk_core(clk_core), .rst_core(rst_core), .flush_req(flush_req), .flush_ack(flush_ack),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .unit_sel_i(unit_sel_i),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i), .unit_data_o(unit_data_o),
    .unit_token_o(unit_token_o), .retire_i(retire_i), .err_o(err_o),
    .stall_count_o(stall_count_o)
  );

  always #5 clk_core = ~clk_core;

  // Reference model state
  logic [DW+TW-1:0] mq [N][$];
  int               m_tok;
  int               m_infl;
  bit               m_flush;
  bit               m_err;
  logic [31:0]      m_stall [N];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx, input logic [159:0] act,
                       input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_stall[i] = '0;
    end
    m_tok = 0; m_infl = 0; m_flush = 0; m_err = 0;
  endtask

  task automatic do_reset();
    rst_core = 1'b1; valid_i = 1'b0; flush_req = 1'b0; retire_i = 1'b0;
    unit_ready_i = '0; unit_sel_i = '0; data_i = '0;
    @(posedge clk_core);
    @(posedge clk_core);
    model_reset();
    @(negedge clk_core);
    rst_core = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare all outputs against the model, advance the model across one edge, and return at the negedge.
  task automatic tick();
    bit legal, rdy, acc;
    int sel, pre_infl;
    logic [N-1:0] ev;
    #1;
    sel   = int'(unit_sel_i);
    legal = (sel < N);
    rdy   = !m_flush && !flush_req && (m_infl < MI) && (!legal || (mq[sel].size() < DEP));
    check("ready_o", 0, 160'(ready_o), 160'(rdy));
    check("flush_ack", 0, 160'(flush_ack), 160'(m_flush));
    check("err_o", 0, 160'(err_o), 160'(m_err));
    for (int i = 0; i < N; i++) begin
      ev[i] = !m_flush && (mq[i].size() > 0);
      check("unit_valid", i, 160'(unit_valid_o[i]), 160'(ev[i]));
      if (ev[i]) begin
        check("head_data", i, 160'(unit_data_o[i*DW +: DW]), 160'(mq[i][0][DW+TW-1:TW]));
        check("head_token", i, 160'(unit_token_o[i*TW +: TW]), 160'(mq[i][0][TW-1:0]));
      end
`ifdef HSV_DISPATCH_STATS_EN
      check("stall_count", i, 160'(stall_count_o[i*32 +: 32]), 160'(m_stall[i]));
`else
      check("stall_count", i, 160'(stall_count_o[i*32 +: 32]), 160'(0));
`endif
    end
    // Model step
    if (!m_flush) begin
      if (flush_req) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        m_infl = 0; m_flush = 1; m_err = 0;
      end else begin
        for (int i = 0; i < N; i++)
          if (valid_i && sel == i && mq[i].size() == DEP && m_stall[i] != 32'hFFFF_FFFF)
            m_stall[i] = m_stall[i] + 32'd1;
        for (int i = 0; i < N; i++)
          if (ev[i] && unit_ready_i[i]) void'(mq[i].pop_front());
        acc      = valid_i && rdy;
        m_err    = acc && !legal;
        pre_infl = m_infl;
        if (acc && legal) begin
          mq[sel].push_back({data_i, TW'(m_tok)});
          m_tok = (m_tok + 1) % (1 << TW);
          m_infl++;
        end
        if (retire_i && pre_infl > 0) m_infl--;
      end
    end else begin
      m_err = 0;
      if (!flush_req) m_flush = 0;
    end
    @(posedge clk_core);
    @(negedge clk_core);
  endtask

  task automatic push(input int sel);
    valid_i = 1'b1; unit_sel_i = 3'(sel); data_i = rnd_data();
    tick();
    valid_i = 1'b0;
  endtask

  int flush_cnt;

  initial begin
    do_reset();
    // Reset state
    #1;
    check("rst_unit_valid", 0, 160'(unit_valid_o), 160'(0));
    check("rst_flush_ack", 0, 160'(flush_ack), 160'(0));
    check("rst_err", 0, 160'(err_o), 160'(0));

    // Accepts to units 0, 2, 0 and token ordering on the heads
    push(0); push(2); push(0);
    #1;
    check("lit_valid_00101", 0, 160'(unit_valid_o), 160'(5'b00101));
    check("lit_tok_u0", 0, 160'(unit_token_o[0 +: TW]), 160'(0));
    check("lit_tok_u2", 2, 160'(unit_token_o[2*TW +: TW]), 160'(1));
    unit_ready_i = 5'b00001;
    tick();
    unit_ready_i = '0;
    #1;
    check("lit_tok_u0_pop", 0, 160'(unit_token_o[0 +: TW]), 160'(2));

    // Full FIFO refuses a push even while it pops
    do_reset();
    push(1); push(1);
    valid_i = 1'b1; unit_sel_i = 3'd1; data_i = rnd_data();
    #1;
    check("lit_full_ready", 1, 160'(ready_o), 160'(0));
    unit_ready_i = 5'b00010;
    #1;
    check("lit_full_pop_ready", 1, 160'(ready_o), 160'(0));
    tick();
    unit_ready_i = '0;
    #1;
    check("lit_after_pop_ready", 1, 160'(ready_o), 160'(1));
    tick();
    valid_i = 1'b0;

    // In-flight limit with retire
    do_reset();
    for (int i = 0; i < 8; i++) push(i % 4);
    valid_i = 1'b1; unit_sel_i = 3'd4; data_i = rnd_data(); retire_i = 1'b1;
    #1;
    check("lit_inflight_block", 0, 160'(ready_o), 160'(0));
    tick();
    retire_i = 1'b0;
    #1;
    check("lit_inflight_free", 0, 160'(ready_o), 160'(1));
    tick();
    #1;
    check("lit_inflight_full", 0, 160'(ready_o), 160'(0));
    valid_i = 1'b0;
    tick();

    // Flush with 4 queued entries; unit_ready_i and retire_i are ignored in FLUSH
    do_reset();
    for (int i = 0; i < 4; i++) push(i);
    flush_req = 1'b1;
    #1;
    check("lit_flush_ack_pre", 0, 160'(flush_ack), 160'(0));
    tick();
    unit_ready_i = '1; retire_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("lit_flush_ack", c, 160'(flush_ack), 160'(1));
      check("lit_flush_valid", c, 160'(unit_valid_o), 160'(0));
      tick();
    end
    flush_req = 1'b0;
    #1;
    check("lit_flush_ack_last", 0, 160'(flush_ack), 160'(1));
    tick();
    unit_ready_i = '0; retire_i = 1'b0;
    #1;
    check("lit_flush_ack_off", 0, 160'(flush_ack), 160'(0));
    push(0);
    #1;
    check("lit_tok_after_flush", 0, 160'(unit_token_o[0 +: TW]), 160'(4));

    // Illegal unit select: accepted and dropped, with a single err pulse
    do_reset();
    valid_i = 1'b1; unit_sel_i = 3'd7; data_i = rnd_data();
    #1;
    check("lit_illegal_ready", 0, 160'(ready_o), 160'(1));
    tick();
    valid_i = 1'b0;
    #1;
    check("lit_err_pulse", 0, 160'(err_o), 160'(1));
    check("lit_illegal_nopush", 0, 160'(unit_valid_o), 160'(0));
    tick();
    #1;
    check("lit_err_clear", 0, 160'(err_o), 160'(0));
    push(0);
    #1;
    check("lit_tok_after_illegal", 0, 160'(unit_token_o[0 +: TW]), 160'(0));

    // Stall statistics toward a full unit 3
    do_reset();
    push(3); push(3);
    valid_i = 1'b1; unit_sel_i = 3'd3;
    for (int c = 0; c < 10; c++) tick();
    valid_i = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
`ifdef HSV_DISPATCH_STATS_EN
      check("lit_stall", i, 160'(stall_count_o[i*32 +: 32]), 160'((i == 3) ? 10 : 0));
`else
      check("lit_stall", i, 160'(stall_count_o[i*32 +: 32]), 160'(0));
`endif
    end
    tick();

    // Randomized phase with occasional flushes and mid-stream resets
    flush_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 1000 == 999) do_reset();
      valid_i      = ($urandom_range(0, 3) != 0);
      unit_sel_i   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      data_i       = rnd_data();
      unit_ready_i = N'($urandom);
      retire_i     = ($urandom_range(0, 2) == 0);
      if (flush_cnt > 0) begin
        flush_req = 1'b1;
        flush_cnt--;
      end else begin
        flush_req = 1'b0;
        if ($urandom_range(0, 49) == 0) flush_cnt = $urandom_range(1, 4);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
